// File: rtl/full_add_4_pkg.sv
// Shared constants and helpers for the full_add_4 ripple-carry adder.
// Holds the production operand width and the signed-overflow rule.
package full_add_4_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Two's-complement overflow: the carry into the sign bit disagrees with the carry out of it.
    function automatic logic signed_overflow(input logic carry_into_msb,
                                             input logic carry_out_of_msb);
        return carry_into_msb ^ carry_out_of_msb;
    endfunction

endpackage

// File: rtl/full_add_4_fa1.sv
// One-bit full adder cell; chained WIDTH times by full_add_4 to form the ripple chain.
module fa1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_prop;

    assign w_prop = a ^ b;
    assign s      = w_prop ^ ci;
    assign co     = (a & b) | (ci & w_prop);

endmodule

// File: rtl/full_add_4.sv
// Ripple-carry adder with zero-latency sum/carry/overflow outputs and a
// one-cycle registered copy of the same three results.
module full_add_4
    import full_add_4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A4,
    input  logic [WIDTH-1:0] B4,
    input  logic             CINf,
    output logic [WIDTH-1:0] SUM4,
    output logic             COUTf,
    output logic             OVFf,
    output logic [WIDTH-1:0] SUM4_q,
    output logic             COUTf_q,
    output logic             OVFf_q
);

    // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   w_carry;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign w_carry[0] = CINf;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        fa1 u_fa1 (
            .a  (A4[gi]),
            .b  (B4[gi]),
            .ci (w_carry[gi]),
            .s  (SUM4[gi]),
            .co (w_carry[gi+1])
        );
    end

    assign COUTf = w_carry[WIDTH];
    assign OVFf  = signed_overflow(w_carry[WIDTH-1], w_carry[WIDTH]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge combinational value, which gives the exact one-cycle latency.
    // NOTE: these are plain flops, not memories, so all of them are cleared by
    // the asynchronous reset and held at zero for as long as rst_n stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_sum  <= SUM4;
            r_cout <= COUTf;
            r_ovf  <= OVFf;
        end
    end

    assign SUM4_q  = r_sum;
    assign COUTf_q = r_cout;
    assign OVFf_q  = r_ovf;

endmodule

// File: tb/tb_full_add_4.sv
// Directed and exhaustive self-checking bench for full_add_4 (WIDTH = 4).
module tb_full_add_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] A4;
    logic [3:0] B4;
    logic       CINf;
    logic [3:0] SUM4;
    logic       COUTf;
    logic       OVFf;
    logic [3:0] SUM4_q;
    logic       COUTf_q;
    logic       OVFf_q;

    int n_tests = 0;
    int n_fail  = 0;

    full_add_4 #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A4      (A4),
        .B4      (B4),
        .CINf    (CINf),
        .SUM4    (SUM4),
        .COUTf   (COUTf),
        .OVFf    (OVFf),
        .SUM4_q  (SUM4_q),
        .COUTf_q (COUTf_q),
        .OVFf_q  (OVFf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_comb(input string tag, input logic [3:0] s, input logic c, input logic v);
        check({tag, " SUM4"},  {4'h0, SUM4},  {4'h0, s});
        check({tag, " COUTf"}, {7'h0, COUTf}, {7'h0, c});
        check({tag, " OVFf"},  {7'h0, OVFf},  {7'h0, v});
    endtask

    task automatic check_reg(input string tag, input logic [3:0] s, input logic c, input logic v);
        check({tag, " SUM4_q"},  {4'h0, SUM4_q},  {4'h0, s});
        check({tag, " COUTf_q"}, {7'h0, COUTf_q}, {7'h0, c});
        check({tag, " OVFf_q"},  {7'h0, OVFf_q},  {7'h0, v});
    endtask

    // Apply on the falling edge, check the combinational result, then the registered copy.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic [3:0] s, input logic c, input logic v);
        @(negedge clk);
        A4 = a; B4 = b; CINf = ci;
        #1;
        check_comb(tag, s, c, v);
        @(posedge clk);
        #1;
        check_reg(tag, s, c, v);
    endtask

    initial begin
        rst_n = 1'b0;
        A4    = 4'h0;
        B4    = 4'h0;
        CINf  = 1'b0;

        // Reset state and combinational tracking while reset is held.
        #2;
        check_comb("rst zero-in", 4'h0, 1'b0, 1'b0);
        check_reg("rst initial", 4'h0, 1'b0, 1'b0);
        A4 = 4'b0001; B4 = 4'b0001;
        #1;
        check_comb("rst tracking", 4'b0010, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_reg("rst held over edge", 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reg("post-release pre-edge", 4'h0, 1'b0, 1'b0);

        // Basic sums.
        step("T2 1+1 c0", 4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);
        step("T2 1+0 c1", 4'b0001, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0);
        step("T2 2+1 c0", 4'b0010, 4'b0001, 1'b0, 4'b0011, 1'b0, 1'b0);
        step("T2 2+0 c1", 4'b0010, 4'b0000, 1'b1, 4'b0011, 1'b0, 1'b0);

        // Carry ripple.
        step("T3 2+1 c1", 4'b0010, 4'b0001, 1'b1, 4'b0100, 1'b0, 1'b0);
        step("T3 A+5 c0", 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0);
        step("T3 A+5 c1", 4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0);

        // Overflow and boundaries.
        step("T4 7+1 c0", 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        step("T4 8+8 c0", 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
        step("T4 F+1 c0", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        step("B F+F c1",  4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
        step("B F+0 c1",  4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        step("B 0+0 c0",  4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Mid-cycle asynchronous reset with nonzero registered outputs.
        step("T1 load 7+1", 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reg("T1 async clear", 4'h0, 1'b0, 1'b0);
        check_comb("T1 comb in reset", 4'b1000, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_reg("T1 held in reset", 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reg("T1 released pre-edge", 4'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_reg("T1 first capture", 4'b1000, 1'b0, 1'b1);

        // Latency: combinational updates at once, register only after the next rising edge.
        @(negedge clk);
        A4 = 4'b0011; B4 = 4'b0100; CINf = 1'b1;
        #1;
        check_comb("T5 comb immediate", 4'b1000, 1'b0, 1'b1);
        check_reg("T5 reg still old", 4'b1000, 1'b0, 1'b1);
        A4 = 4'b0101; B4 = 4'b0010; CINf = 1'b0;
        #1;
        check_comb("T5 comb second", 4'b0111, 1'b0, 1'b0);
        check_reg("T5 reg unchanged", 4'b1000, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_reg("T5 reg after edge", 4'b0111, 1'b0, 1'b0);

        // Exhaustive sweep against a behavioural integer model.
        for (int i = 0; i < 512; i++) begin
            logic [4:0] full;
            int         sa;
            int         sb;
            int         ssum;
            logic       exp_ovf;
            @(negedge clk);
            A4   = i[8:5];
            B4   = i[4:1];
            CINf = i[0];
            full = {1'b0, i[8:5]} + {1'b0, i[4:1]} + {4'b0, i[0]};
            sa   = i[8] ? int'(i[8:5]) - 16 : int'(i[8:5]);
            sb   = i[4] ? int'(i[4:1]) - 16 : int'(i[4:1]);
            ssum = sa + sb + int'(i[0]);
            exp_ovf = (ssum > 7) || (ssum < -8);
            #1;
            check_comb("T6 comb", full[3:0], full[4], exp_ovf);
            @(posedge clk); #1;
            check_reg("T6 reg", full[3:0], full[4], exp_ovf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
